// File: rtl/nor_vector_driver.sv
// Stimulus driver and return-path checker for a 2-input NOR cell.
// Steps {in2,in1} through 00,01,10,11 for NPASS passes and counts output mismatches.
module nor_vector_driver #(
  parameter int SETTLE = 2,
  parameter int NPASS  = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_out,
  output logic             in1,
  output logic             in2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PC_W = $clog2(NPASS + 1);
  localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [PC_W-1:0]  PASS_LAST   = PC_W'(NPASS - 1);
  localparam logic [CNT_W-1:0] ERR_MAX     = '1;

  state_t          state, state_nxt;
  logic [1:0]      idx;
  logic [PC_W-1:0] pass_cnt;
  logic [SC_W-1:0] settle_cnt;
  logic            expected;
  logic            mismatch;
  logic            last_vec;

  assign expected = ~(in1 | in2);
  // NOTE: case inequality makes an X or Z from the cell count as a mismatch in simulation.
  assign mismatch = (dut_out !== expected);
  assign last_vec = (idx == 2'd3) && (pass_cnt == PASS_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_APPLY;
      ST_APPLY:  state_nxt = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = last_vec ? ST_DONE : ST_APPLY;
      ST_DONE:   if (start) state_nxt = ST_APPLY;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_CHECK);
    done = (state == ST_DONE);
    pass = done && (err_count == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in1        <= 1'b0;
      in2        <= 1'b0;
      idx        <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx        <= '0;
            pass_cnt   <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
          end
        end
        ST_APPLY: begin
          in1        <= idx[0];
          in2        <= idx[1];
          settle_cnt <= '0;
        end
        ST_SETTLE: settle_cnt <= settle_cnt + 1'b1;
        ST_CHECK: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= {in2, in1};
            end
          end
          idx <= idx + 2'd1;
          if (idx == 2'd3) pass_cnt <= pass_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nor_vector_driver.sv
// Bench for nor_vector_driver: three parameterisations, a behavioural cell with
// selectable faults, a vector scoreboard and a table of end-of-run expectations.
module tb_nor_vector_driver;

  localparam int S_TAB [3] = '{2, 2, 0};
  localparam int N_TAB [3] = '{4, 4, 1};
  localparam int C_TAB [3] = '{8, 3, 8};

  // Cell behaviour: 0 correct NOR, 1 stuck 0, 2 stuck 1, 3 inverted (OR)
  typedef struct {
    int         inst;
    logic [1:0] mode;
    bit         mid_start;
    int         exp_err;
    logic       exp_fv;
    logic [1:0] exp_fvec;
    logic       exp_pass;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [3];
  logic [1:0] mode  [3];
  logic       in1_w [3];
  logic       in2_w [3];
  logic       busy_w[3];
  logic       done_w[3];
  logic       pass_w[3];
  logic       fv_w  [3];
  logic [1:0] fvec_w[3];
  logic [7:0] err_w [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic cell_model(input logic [1:0] m, input logic a, input logic b);
    case (m)
      2'd0:    return ~(a | b);
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return a | b;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = C_TAB[g];
    logic          l_in1, l_in2, l_busy, l_done, l_pass, l_fv, l_dut;
    logic [1:0]    l_fvec;
    logic [CW-1:0] l_err;

    assign l_dut = cell_model(mode[g], l_in1, l_in2);

    nor_vector_driver #(
      .SETTLE(S_TAB[g]),
      .NPASS (N_TAB[g]),
      .CNT_W (CW)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start[g]),
      .dut_out   (l_dut),
      .in1       (l_in1),
      .in2       (l_in2),
      .busy      (l_busy),
      .done      (l_done),
      .pass      (l_pass),
      .err_count (l_err),
      .fail_valid(l_fv),
      .fail_vec  (l_fvec)
    );

    assign in1_w[g]  = l_in1;
    assign in2_w[g]  = l_in2;
    assign busy_w[g] = l_busy;
    assign done_w[g] = l_done;
    assign pass_w[g] = l_pass;
    assign fv_w[g]   = l_fv;
    assign fvec_w[g] = l_fvec;
    assign err_w[g]  = 8'(l_err);
  end

  task automatic check(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s inst=%0d: got %0h, expected %0h", name, inst, got, exp);
    end
  endtask

  task automatic check_all_zero(input int i);
    check("rst_in1",  i, 32'(in1_w[i]),  0);
    check("rst_in2",  i, 32'(in2_w[i]),  0);
    check("rst_busy", i, 32'(busy_w[i]), 0);
    check("rst_done", i, 32'(done_w[i]), 0);
    check("rst_pass", i, 32'(pass_w[i]), 0);
    check("rst_err",  i, 32'(err_w[i]),  0);
    check("rst_fv",   i, 32'(fv_w[i]),   0);
    check("rst_fvec", i, 32'(fvec_w[i]), 0);
  endtask

  // One full run with fixed timing; the vector scoreboard is filled at start.
  task automatic run(input int i, input logic [1:0] md, input bit mid);
    int         s = S_TAB[i];
    int         n = N_TAB[i];
    logic [1:0] q[$];
    logic [1:0] v;
    mode[i] = md;
    @(negedge clk);
    start[i] = 1'b1;
    for (int p = 0; p < n; p++)
      for (int k = 0; k < 4; k++) q.push_back(2'(k));
    @(negedge clk);
    start[i] = 1'b0;
    check("apply_busy", i, 32'(busy_w[i]), 1);
    check("apply_done", i, 32'(done_w[i]), 0);
    check("apply_err",  i, 32'(err_w[i]),  0);
    check("apply_fv",   i, 32'(fv_w[i]),   0);
    for (int k = 0; k < 4 * n; k++) begin
      if (mid && k == 5) start[i] = 1'b1;
      repeat (s + 1) begin
        @(negedge clk);
        start[i] = 1'b0;
      end
      v = q.pop_front();
      check("check_vec",  i, 32'({in2_w[i], in1_w[i]}), 32'(v));
      check("check_busy", i, 32'(busy_w[i]), 1);
      @(negedge clk);
    end
    check("end_done", i, 32'(done_w[i]), 1);
    check("end_busy", i, 32'(busy_w[i]), 0);
    check("end_in1",  i, 32'(in1_w[i]),  1);
    check("end_in2",  i, 32'(in2_w[i]),  1);
  endtask

  vec_t tbl [10];

  initial begin
    tbl[0] = '{0, 2'd0, 1'b0,  0, 1'b0, 2'b00, 1'b1};
    tbl[1] = '{0, 2'd1, 1'b0,  4, 1'b1, 2'b00, 1'b0};
    tbl[2] = '{0, 2'd0, 1'b1,  0, 1'b0, 2'b00, 1'b1};
    tbl[3] = '{0, 2'd2, 1'b0, 12, 1'b1, 2'b01, 1'b0};
    tbl[4] = '{0, 2'd3, 1'b0, 16, 1'b1, 2'b00, 1'b0};
    tbl[5] = '{1, 2'd3, 1'b0,  7, 1'b1, 2'b00, 1'b0};
    tbl[6] = '{1, 2'd2, 1'b0,  7, 1'b1, 2'b01, 1'b0};
    tbl[7] = '{2, 2'd0, 1'b0,  0, 1'b0, 2'b00, 1'b1};
    tbl[8] = '{2, 2'd1, 1'b0,  1, 1'b1, 2'b00, 1'b0};
    tbl[9] = '{2, 2'd2, 1'b0,  3, 1'b1, 2'b01, 1'b0};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      mode[i]  = 2'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_all_zero(i);
    rst = 1'b0;

    // Reset during the third vector, with start asserted on the same edge
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_vec", 0, 32'({in2_w[0], in1_w[0]}), 32'(2'b10));
    rst      = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    check_all_zero(0);
    rst      = 1'b0;
    start[0] = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 0, 32'(busy_w[0]), 0);

    for (int t = 0; t < 10; t++) begin
      run(tbl[t].inst, tbl[t].mode, tbl[t].mid_start);
      check("err_count",  tbl[t].inst, 32'(err_w[tbl[t].inst]),  32'(tbl[t].exp_err));
      check("fail_valid", tbl[t].inst, 32'(fv_w[tbl[t].inst]),   32'(tbl[t].exp_fv));
      check("fail_vec",   tbl[t].inst, 32'(fvec_w[tbl[t].inst]), 32'(tbl[t].exp_fvec));
      check("pass",       tbl[t].inst, 32'(pass_w[tbl[t].inst]), 32'(tbl[t].exp_pass));
    end

    // done and results hold in DONE with no further start
    repeat (5) @(negedge clk);
    check("hold_done", 2, 32'(done_w[2]), 1);
    check("hold_err",  2, 32'(err_w[2]),  3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
